// File: rtl/time_tx_pkg.sv
// -----------------------------------------------------------------------------
// time_tx_pkg
// Shared definitions for the stopwatch ASCII time transmitter:
//   - FSM state encodings (IDLE, CONV, EMIT)
//   - ASCII constants used to build the "MM:SS.hh" frame
//   - conversion latency of the bin2bcd_seq converters
//   - small helpers for digit encoding and input clamping
// -----------------------------------------------------------------------------
package time_tx_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // One double-dabble iteration per input bit.
    localparam int CONV_CYCLES = 10;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return ASCII_ZERO + {4'd0, d};
    endfunction

    function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter: 10-bit binary to 3-digit BCD.
// A start pulse loads the operand; exactly CONV_CYCLES later done pulses for
// one cycle and bcd holds the result until the next start.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   start  : load bin and begin conversion
//   bin    : binary operand (values above 999 do not fit the result)
//   bcd    : {hundreds, tens, units}
//   done   : one-cycle pulse when bcd is valid
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import time_tx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  bin,
    output logic [11:0] bcd,
    output logic        done
);

    // {bcd digits[11:0], binary bits still to shift in[9:0]}
    logic [21:0] sr_reg;
    logic [21:0] sr_adj;
    logic [3:0]  cnt_reg;
    logic        done_reg;

    // Add 3 to every BCD nibble >= 5 before the shift.
    always_comb begin
        sr_adj = sr_reg;
        for (int n = 0; n < 3; n++) begin
            if (sr_reg[10 + 4*n +: 4] >= 4'd5)
                sr_adj[10 + 4*n +: 4] = sr_reg[10 + 4*n +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_reg   <= '0;
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                sr_reg  <= {12'd0, bin};
                cnt_reg <= 4'(CONV_CYCLES);
            end else if (cnt_reg != 4'd0) begin
                sr_reg  <= {sr_adj[20:0], 1'b0};
                cnt_reg <= cnt_reg - 4'd1;
                if (cnt_reg == 4'd1)
                    done_reg <= 1'b1;
            end
        end
    end

    assign bcd  = sr_reg[21:10];
    assign done = done_reg;

endmodule

// File: rtl/time_ascii_tx.sv
// -----------------------------------------------------------------------------
// time_ascii_tx
// Snapshots the stopwatch time on a send pulse and streams it to the UART TX
// byte interface as ASCII "MM:SS.hh" (MIN_DIGITS minute digits).
// Optional terminator: define TIME_TX_CRLF_EN to append CR LF to each frame.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   send           : request a frame (sampled only in IDLE)
//   minutes/seconds/hundreth_sec : binary time inputs
//   tx_data/tx_valid/tx_ready    : byte stream, valid/ready handshake
//   busy           : high from snapshot until the last byte is accepted
//   done           : one-cycle pulse in the first IDLE cycle after a frame
// -----------------------------------------------------------------------------
module time_ascii_tx
    import time_tx_pkg::*;
#(
    parameter int MIN_DIGITS = 2
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [9:0] minutes,
    input  logic [9:0] seconds,
    input  logic [9:0] hundreth_sec,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    localparam logic [9:0] MIN_MAX = (MIN_DIGITS == 3) ? 10'd999 : 10'd99;
`ifdef TIME_TX_CRLF_EN
    localparam int FRAME_LEN = MIN_DIGITS + 8;
`else
    localparam int FRAME_LEN = MIN_DIGITS + 6;
`endif
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    logic [1:0]  state_reg;
    logic [3:0]  idx_reg;
    logic        done_reg;
    logic        start;
    logic [11:0] min_bcd, sec_bcd, hs_bcd;
    logic        min_done, sec_done, hs_done;
    logic [7:0]  byte_sel;
    logic        unused_hi;

    // The converters latch their operands on start, so they double as the
    // snapshot: later input changes cannot reach the frame.
    assign start = (state_reg == IDLE) && send;

    bin2bcd_seq u_min (
        .clk(clk), .reset(reset), .start(start),
        .bin(clamp10(minutes, MIN_MAX)), .bcd(min_bcd), .done(min_done)
    );
    bin2bcd_seq u_sec (
        .clk(clk), .reset(reset), .start(start),
        .bin(clamp10(seconds, 10'd99)), .bcd(sec_bcd), .done(sec_done)
    );
    bin2bcd_seq u_hs (
        .clk(clk), .reset(reset), .start(start),
        .bin(clamp10(hundreth_sec, 10'd99)), .bcd(hs_bcd), .done(hs_done)
    );

    // Seconds and hundredths are clamped to 99, so their hundreds digit is 0.
    assign unused_hi = ^{sec_bcd[11:8], hs_bcd[11:8]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: if (send) state_reg <= CONV;
                CONV: begin
                    // All three converters share the same fixed latency.
                    if (min_done && sec_done && hs_done) begin
                        state_reg <= EMIT;
                        idx_reg   <= '0;
                    end
                end
                EMIT: begin
                    if (tx_ready) begin
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                        end else begin
                            idx_reg <= idx_reg + 4'd1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Byte position relative to the colon: negative positions are minute
    // digits, most significant first.
    always_comb begin
        int rel;
        logic [1:0] dsel;
        byte_sel = 8'h00;
        rel      = int'(idx_reg) - MIN_DIGITS;
        dsel     = 2'(-rel - 1);
        if (rel < 0) begin
            byte_sel = digit_ascii(min_bcd[4*dsel +: 4]);
        end else begin
            case (rel)
                0: byte_sel = ASCII_COLON;
                1: byte_sel = digit_ascii(sec_bcd[7:4]);
                2: byte_sel = digit_ascii(sec_bcd[3:0]);
                3: byte_sel = ASCII_DOT;
                4: byte_sel = digit_ascii(hs_bcd[7:4]);
                5: byte_sel = digit_ascii(hs_bcd[3:0]);
`ifdef TIME_TX_CRLF_EN
                6: byte_sel = ASCII_CR;
                7: byte_sel = ASCII_LF;
`endif
                default: byte_sel = 8'h00;
            endcase
        end
    end

    assign tx_valid = (state_reg == EMIT);
    assign tx_data  = (state_reg == EMIT) ? byte_sel : 8'h00;
    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;

endmodule

// File: tb/tb_time_ascii_tx.sv
// -----------------------------------------------------------------------------
// tb_time_ascii_tx
// Scoreboard bench for time_ascii_tx: a MIN_DIGITS=2 instance (main tests)
// and a MIN_DIGITS=3 instance. Expected frames are hand-written strings.
// -----------------------------------------------------------------------------
module tb_time_ascii_tx;

    typedef struct {
        logic [7:0] data;
        bit         last;
    } exp_t;

`ifdef TIME_TX_CRLF_EN
    localparam int TERM = 2;
`else
    localparam int TERM = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       send, send3;
    logic [9:0] minutes, seconds, hsec;
    logic       ready, ready3;
    logic [7:0] tx_data, tx_data3;
    logic       tx_valid, tx_valid3, busy, busy3, done, done3;

    int   checks = 0;
    int   failures = 0;
    exp_t q2[$];
    exp_t q3[$];
    bit   pend2 = 0, pend3 = 0, stall2 = 0;
    logic [7:0] sdata2 = 8'h00;

    always #5 clk = ~clk;

    time_ascii_tx #(.MIN_DIGITS(2)) dut (
        .clk(clk), .reset(reset), .send(send),
        .minutes(minutes), .seconds(seconds), .hundreth_sec(hsec),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(ready),
        .busy(busy), .done(done)
    );

    time_ascii_tx #(.MIN_DIGITS(3)) dut3 (
        .clk(clk), .reset(reset), .send(send3),
        .minutes(minutes), .seconds(seconds), .hundreth_sec(hsec),
        .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(ready3),
        .busy(busy3), .done(done3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue the body bytes (plus terminator when enabled) for one frame.
    task automatic push_exp(input int which, input logic [71:0] body, input int n);
        exp_t e;
        int total;
        total = n + TERM;
        for (int i = 0; i < total; i++) begin
            if (i < n)       e.data = body[8*(n-1-i) +: 8];
            else if (i == n) e.data = 8'h0D;
            else             e.data = 8'h0A;
            e.last = (i == total - 1);
            if (which == 3) q3.push_back(e);
            else            q2.push_back(e);
        end
    endtask

    // Drive a send for one edge, scramble inputs afterwards, check latency.
    // Returns at the negedge after the edge where tx_valid should rise.
    task automatic start_frame(input int which, input logic [9:0] m, input logic [9:0] s,
                               input logic [9:0] h, input logic [71:0] body, input int n);
        minutes = m; seconds = s; hsec = h;
        push_exp(which, body, n);
        if (which == 3) send3 = 1'b1; else send = 1'b1;
        @(posedge clk);
        #1;
        send = 1'b0; send3 = 1'b0;
        minutes = 10'd1; seconds = 10'd1; hsec = 10'd1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("latency_pre", (which == 3) ? tx_valid3 : tx_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("latency_first", (which == 3) ? tx_valid3 : tx_valid, 1'b1);
    endtask

    task automatic wait_idle(input int which);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (which == 3) begin
                if (!busy3 && q3.size() == 0 && !pend3) begin ok = 1; break; end
            end else begin
                if (!busy && q2.size() == 0 && !pend2) begin ok = 1; break; end
            end
        end
        check("frame_complete", ok, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    // Monitor, MIN_DIGITS=2 instance.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            pend2 = 0; stall2 = 0;
        end else begin
            if (pend2) begin
                check("done_pulse", done, 1'b1);
                pend2 = 0;
            end else if (done) begin
                check("done_spurious", done, 1'b0);
            end
            if (stall2) begin
                check("hold_valid", tx_valid, 1'b1);
                check("hold_data", tx_data, sdata2);
            end
            stall2 = tx_valid && !ready;
            sdata2 = tx_data;
            if (tx_valid && ready) begin
                if (q2.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_byte: got %0h expected no byte at %0t", tx_data, $time);
                end else begin
                    e = q2.pop_front();
                    check("byte", tx_data, e.data);
                    $display("xfer dut2 byte=%02h expected=%02h", tx_data, e.data);
                    if (e.last) pend2 = 1;
                end
            end
        end
    end

    // Monitor, MIN_DIGITS=3 instance (always ready).
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            pend3 = 0;
        end else begin
            if (pend3) begin
                check("done3_pulse", done3, 1'b1);
                pend3 = 0;
            end else if (done3) begin
                check("done3_spurious", done3, 1'b0);
            end
            if (tx_valid3 && ready3) begin
                if (q3.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_byte3: got %0h expected no byte at %0t", tx_data3, $time);
                end else begin
                    e = q3.pop_front();
                    check("byte3", tx_data3, e.data);
                    $display("xfer dut3 byte=%02h expected=%02h", tx_data3, e.data);
                    if (e.last) pend3 = 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset = 1'b0; send = 1'b0; send3 = 1'b0;
        minutes = '0; seconds = '0; hsec = '0;
        ready = 1'b1; ready3 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // Basic frame
        start_frame(2, 10'd3, 10'd7, 10'd45, "03:07.45", 8);
        check("busy_in_frame", busy, 1'b1);
        wait_idle(2);
        check("busy_after", busy, 1'b0);

        // Further directed vectors, including clamping and snapshot
        start_frame(2, 10'd0, 10'd0, 10'd0, "00:00.00", 8);          wait_idle(2);
        start_frame(2, 10'd150, 10'd99, 10'd0, "99:99.00", 8);       wait_idle(2);
        start_frame(2, 10'd1023, 10'd1023, 10'd1023, "99:99.99", 8); wait_idle(2);
        start_frame(2, 10'd12, 10'd34, 10'd56, "12:34.56", 8);       wait_idle(2);

        // Backpressure on the colon byte for 5 edges
        start_frame(2, 10'd3, 10'd7, 10'd45, "03:07.45", 8);
        @(posedge clk); @(posedge clk);
        #1 ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_colon", tx_data, 8'h3A);
        end
        @(posedge clk);
        #1 ready = 1'b1;
        wait_idle(2);

        // send while busy is ignored
        start_frame(2, 10'd12, 10'd34, 10'd56, "12:34.56", 8);
        @(posedge clk);
        #1 send = 1'b1; minutes = 10'd0;
        @(posedge clk);
        #1 send = 1'b0;
        check("busy_ignore", busy, 1'b1);
        wait_idle(2);
        repeat (20) @(negedge clk);

        // send in the done cycle starts a new frame
        start_frame(2, 10'd59, 10'd59, 10'd99, "59:59.99", 8);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        check("done_seen", seen, 1'b1);
        start_frame(2, 10'd0, 10'd0, 10'd7, "00:00.07", 8);
        wait_idle(2);

        // Reset during the fourth byte
        start_frame(2, 10'd3, 10'd7, 10'd45, "03:07.45", 8);
        @(posedge clk); @(posedge clk); @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_valid", tx_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_data", tx_data, 8'h00);
        q2.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        start_frame(2, 10'd1, 10'd2, 10'd3, "01:02.03", 8);
        wait_idle(2);

        // Three-digit minutes instance
        start_frame(3, 10'd150, 10'd2, 10'd9, "150:02.09", 9);       wait_idle(3);
        check("busy3_after", busy3, 1'b0);
        start_frame(3, 10'd1023, 10'd100, 10'd100, "999:99.99", 9);  wait_idle(3);
        start_frame(3, 10'd7, 10'd0, 10'd5, "007:00.05", 9);         wait_idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
